// File: rtl/ad7846_readback.sv
// Read-side controller for one AD7846 DAC: reads the input latch over the
// shared bus and reports the word with a compare against the expected value.
module ad7846_readback #(
    parameter int SETUP_CYC   = 2,
    parameter int ACCESS_CYC  = 4,
    parameter int HOLD_CYC    = 2,
    parameter int GNT_TIMEOUT = 255
) (
    input  logic        sysclk,
    input  logic        rst,
    input  logic        rb_req,
    input  logic [15:0] rb_expect,
    output logic        rb_ready,
    output logic        rb_valid,
    output logic [15:0] rb_data,
    output logic        rb_match,
    output logic        rb_err,
    input  logic        rb_ack,
    output logic        bus_req,
    input  logic        bus_gnt,
    input  logic [15:0] DATA_i,
    output logic        DATA_OE,
    output logic        RW,
    output logic        CS
);

    typedef enum logic [2:0] {
        IDLE, WAIT_GNT, SETUP, ACCESS, RELEASE, RESULT
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [15:0] expect_q, expect_nxt;
    logic [15:0] data_nxt;
    logic        match_nxt, err_nxt;
    logic        cs_nxt, bus_req_nxt, ready_nxt, valid_nxt;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            expect_q <= 16'd0;
            rb_ready <= 1'b1;
            rb_valid <= 1'b0;
            rb_data  <= 16'd0;
            rb_match <= 1'b0;
            rb_err   <= 1'b0;
            bus_req  <= 1'b0;
            CS       <= 1'b1;
            RW       <= 1'b1;
            DATA_OE  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            expect_q <= expect_nxt;
            rb_ready <= ready_nxt;
            rb_valid <= valid_nxt;
            rb_data  <= data_nxt;
            rb_match <= match_nxt;
            rb_err   <= err_nxt;
            bus_req  <= bus_req_nxt;
            CS       <= cs_nxt;
            // This block only ever reads, so the bus is never driven.
            RW       <= 1'b1;
            DATA_OE  <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (rb_req) begin
                    state_nxt = WAIT_GNT;
                    cnt_nxt   = 8'd0;
                end
            end
            WAIT_GNT: begin
                // A grant on the timeout cycle takes priority.
                if (bus_gnt) begin
                    state_nxt = SETUP;
                    cnt_nxt   = 8'(SETUP_CYC - 1);
                end else if (cnt == 8'(GNT_TIMEOUT - 1)) begin
                    state_nxt = RESULT;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            SETUP: begin
                if (cnt == 8'd0) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = 8'(ACCESS_CYC - 1);
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            ACCESS: begin
                if (cnt == 8'd0) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = 8'(HOLD_CYC - 1);
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            RELEASE: begin
                if (cnt == 8'd0) state_nxt = RESULT;
                else             cnt_nxt   = cnt - 8'd1;
            end
            RESULT: begin
                if (rb_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        expect_nxt  = expect_q;
        data_nxt    = rb_data;
        match_nxt   = rb_match;
        err_nxt     = rb_err;
        ready_nxt   = (state_nxt == IDLE);
        valid_nxt   = (state_nxt == RESULT);
        cs_nxt      = (state_nxt != ACCESS);
        bus_req_nxt = (state_nxt == WAIT_GNT) || (state_nxt == SETUP) ||
                      (state_nxt == ACCESS) || (state_nxt == RELEASE);
        if (state == IDLE && state_nxt == WAIT_GNT) begin
            expect_nxt = rb_expect;
        end
        if (state == ACCESS && state_nxt == RELEASE) begin
            data_nxt  = DATA_i;
            match_nxt = (DATA_i == expect_q);
        end
        if (state == WAIT_GNT && state_nxt == RESULT) begin
            data_nxt  = 16'd0;
            match_nxt = 1'b0;
            err_nxt   = 1'b1;
        end
        if (state == RESULT && state_nxt == IDLE) begin
            err_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_ad7846_readback.sv
// Directed bench for ad7846_readback: timing of CS/rb_valid, compare,
// grant timeout, held results and mid-access reset.
module tb_ad7846_readback;

    logic        sysclk = 1'b0;
    logic        rst;
    logic        rb_req;
    logic [15:0] rb_expect;
    logic        rb_ready;
    logic        rb_valid;
    logic [15:0] rb_data;
    logic        rb_match;
    logic        rb_err;
    logic        rb_ack;
    logic        bus_req;
    logic        bus_gnt;
    logic [15:0] DATA_i;
    logic        DATA_OE;
    logic        RW;
    logic        CS;

    int checks = 0;
    int errors = 0;

    ad7846_readback dut (
        .sysclk    (sysclk),
        .rst       (rst),
        .rb_req    (rb_req),
        .rb_expect (rb_expect),
        .rb_ready  (rb_ready),
        .rb_valid  (rb_valid),
        .rb_data   (rb_data),
        .rb_match  (rb_match),
        .rb_err    (rb_err),
        .rb_ack    (rb_ack),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .DATA_i    (DATA_i),
        .DATA_OE   (DATA_OE),
        .RW        (RW),
        .CS        (CS)
    );

    always #5 sysclk = ~sysclk;

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    // Runs one read with the current bus_gnt/DATA_i and checks its timing.
    task automatic run_read(input string nm, input logic [15:0] exp_v,
                            input logic [15:0] dat, input logic exp_m);
        int cs_first;
        int cs_cnt;
        int v_edge;
        rb_expect = exp_v;
        DATA_i    = dat;
        rb_req    = 1'b1;
        step();
        rb_req    = 1'b0;
        rb_expect = 16'h0000;
        cs_first = -1;
        cs_cnt   = 0;
        v_edge   = -1;
        for (int e = 1; e <= 30 && v_edge < 0; e++) begin
            step();
            if (CS === 1'b0) begin
                cs_cnt++;
                if (cs_first < 0) cs_first = e;
            end
            if (rb_valid === 1'b1) v_edge = e;
        end
        checks++;
        if (cs_first !== 3) begin
            errors++;
            $display("FAIL %s cs_start got=%0d exp=3", nm, cs_first);
        end
        checks++;
        if (cs_cnt !== 4) begin
            errors++;
            $display("FAIL %s cs_len got=%0d exp=4", nm, cs_cnt);
        end
        checks++;
        if (v_edge !== 9) begin
            errors++;
            $display("FAIL %s valid_edge got=%0d exp=9", nm, v_edge);
        end
        checks++;
        if ({rb_data, rb_match, rb_err, bus_req} !== {dat, exp_m, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL %s result got=%h/%b/%b/%b exp=%h/%b/0/0",
                     nm, rb_data, rb_match, rb_err, bus_req, dat, exp_m);
        end
    endtask

    task automatic do_ack(input string nm);
        rb_ack = 1'b1;
        step();
        rb_ack = 1'b0;
        checks++;
        if ({rb_valid, rb_ready, rb_err} !== 3'b010) begin
            errors++;
            $display("FAIL %s ack got valid=%b ready=%b err=%b exp 0/1/0",
                     nm, rb_valid, rb_ready, rb_err);
        end
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({CS, RW, DATA_OE, bus_req, rb_ready, rb_valid, rb_data, rb_match, rb_err}
            !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_vals got CS=%b RW=%b OE=%b req=%b rdy=%b v=%b d=%h",
                     CS, RW, DATA_OE, bus_req, rb_ready, rb_valid, rb_data);
        end
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if ({CS, RW, DATA_OE, bus_req, rb_ready, rb_valid} !== 6'b110010) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL idle_stable got=%0d bad cycles exp=0", bad);
        end
    endtask

    task automatic test_match();
        bus_gnt = 1'b1;
        run_read("match", 16'hA5C3, 16'hA5C3, 1'b1);
        do_ack("match");
    endtask

    task automatic test_mismatch();
        bus_gnt = 1'b1;
        run_read("mismatch", 16'h1234, 16'h1235, 1'b0);
        do_ack("mismatch");
    endtask

    task automatic test_timeout();
        int v_edge;
        bit cs_low;
        bus_gnt = 1'b0;
        rb_req  = 1'b1;
        step();
        rb_req = 1'b0;
        v_edge = -1;
        cs_low = 1'b0;
        for (int e = 1; e <= 300 && v_edge < 0; e++) begin
            step();
            if (CS !== 1'b1) cs_low = 1'b1;
            if (rb_valid === 1'b1) v_edge = e;
        end
        checks++;
        if (v_edge !== 255) begin
            errors++;
            $display("FAIL timeout_edge got=%0d exp=255", v_edge);
        end
        checks++;
        if (cs_low !== 1'b0) begin
            errors++;
            $display("FAIL timeout_cs got=low exp=high");
        end
        checks++;
        if ({rb_err, rb_data, rb_match, bus_req} !== {1'b1, 16'h0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL timeout_result got err=%b d=%h m=%b req=%b exp 1/0000/0/0",
                     rb_err, rb_data, rb_match, bus_req);
        end
        do_ack("timeout");
    endtask

    task automatic test_late_grant();
        int v_edge;
        int cs_first;
        bus_gnt   = 1'b0;
        DATA_i    = 16'h5A5A;
        rb_expect = 16'h5A5A;
        rb_req    = 1'b1;
        step();
        rb_req = 1'b0;
        for (int e = 1; e <= 254; e++) step();
        bus_gnt  = 1'b1;
        v_edge   = -1;
        cs_first = -1;
        for (int e = 255; e <= 300 && v_edge < 0; e++) begin
            step();
            if (CS === 1'b0 && cs_first < 0) cs_first = e;
            if (rb_valid === 1'b1) v_edge = e;
        end
        checks++;
        if (cs_first !== 257) begin
            errors++;
            $display("FAIL late_gnt_cs got=%0d exp=257", cs_first);
        end
        checks++;
        if (v_edge !== 263) begin
            errors++;
            $display("FAIL late_gnt_valid got=%0d exp=263", v_edge);
        end
        checks++;
        if ({rb_err, rb_data, rb_match} !== {1'b0, 16'h5A5A, 1'b1}) begin
            errors++;
            $display("FAIL late_gnt_result got err=%b d=%h m=%b exp 0/5a5a/1",
                     rb_err, rb_data, rb_match);
        end
        do_ack("late_gnt");
    endtask

    task automatic test_hold_result();
        int bad;
        bus_gnt = 1'b1;
        run_read("hold", 16'h0F0F, 16'hF00F, 1'b0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            rb_req    = i[0];
            rb_expect = 16'h0F0F;
            DATA_i    = 16'h1111;
            step();
            if ({rb_valid, rb_ready, rb_data, rb_match, rb_err} !==
                {1'b1, 1'b0, 16'hF00F, 1'b0, 1'b0}) bad++;
        end
        rb_req = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL hold_stable got=%0d bad cycles exp=0", bad);
        end
        do_ack("hold");
    endtask

    task automatic test_reset_mid();
        bit seen;
        bus_gnt   = 1'b1;
        rb_expect = 16'hBEEF;
        rb_req    = 1'b1;
        step();
        rb_req = 1'b0;
        for (int e = 1; e <= 4; e++) step();
        checks++;
        if (CS !== 1'b0) begin
            errors++;
            $display("FAIL mid_access got CS=%b exp=0", CS);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({CS, bus_req, rb_valid, rb_ready} !== 4'b1001) begin
            errors++;
            $display("FAIL mid_reset got CS=%b req=%b v=%b rdy=%b exp 1/0/0/1",
                     CS, bus_req, rb_valid, rb_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (rb_valid !== 1'b0 || CS !== 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_quiet got activity exp=none");
        end
        run_read("after_reset", 16'hC001, 16'hC001, 1'b1);
        do_ack("after_reset");
    endtask

    initial begin
        rst       = 1'b1;
        rb_req    = 1'b0;
        rb_expect = 16'h0000;
        rb_ack    = 1'b0;
        bus_gnt   = 1'b0;
        DATA_i    = 16'h0000;
        test_reset();
        test_match();
        test_mismatch();
        test_timeout();
        test_late_grant();
        test_hold_result();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
